// File: rtl/ct_spsram_256x23_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ct_spsram_ctrl_pkg
// Purpose: Shared defaults and FSM state type for the single-port SRAM
//          controller (256 x 23) and its arbiter.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package ct_spsram_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 23;
  localparam int unsigned DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

  // WAIT: one idle cycle after reset, INIT: zero sweep, RUN: serving requests
  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ct_spsram_256x23_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ct_spsram_256x23_ctrl_if
// Purpose: Bundles the two requester ports, the read-return channel, the
//          flush/init status and the SRAM macro pins of the controller.
// Ports  : modport slave  - the controller
//          modport master - requesters plus the external SRAM macro
// Rev    : 1.0  initial release
// ============================================================================
interface ct_spsram_256x23_ctrl_if
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  flush_req;
  logic                  init_done;

  logic                  p0_req;
  logic                  p0_wr;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic [DATA_WIDTH-1:0] p0_wmask;
  logic                  p0_gnt;

  logic                  p1_req;
  logic                  p1_wr;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic [DATA_WIDTH-1:0] p1_wmask;
  logic                  p1_gnt;

  logic                  rd_vld;
  logic                  rd_id;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_cen;
  logic                  ram_gwen;
  logic [DATA_WIDTH-1:0] ram_wen;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  flush_req,
    output init_done,
    input  p0_req, p0_wr, p0_addr, p0_wdata, p0_wmask,
    output p0_gnt,
    input  p1_req, p1_wr, p1_addr, p1_wdata, p1_wmask,
    output p1_gnt,
    output rd_vld, rd_id, rd_data,
    output ram_a, ram_cen, ram_gwen, ram_wen, ram_d,
    input  ram_q
  );

  modport master (
    output flush_req,
    input  init_done,
    output p0_req, p0_wr, p0_addr, p0_wdata, p0_wmask,
    input  p0_gnt,
    output p1_req, p1_wr, p1_addr, p1_wdata, p1_wmask,
    input  p1_gnt,
    input  rd_vld, rd_id, rd_data,
    input  ram_a, ram_cen, ram_gwen, ram_wen, ram_d,
    output ram_q
  );

endinterface
`default_nettype wire

// File: rtl/ct_spsram_256x23_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module : ct_spsram_rr_arb2
// Purpose: Two-way round-robin arbiter. A lone requester wins immediately;
//          on a tie the port that did not win most recently is granted.
// Ports  : clk, rst      - clock, asynchronous active-high reset
//          en_i          - grants allowed only while high
//          req_i[1:0]    - request vector
//          gnt_o[1:0]    - one-hot (or zero) grant, combinational
// Rev    : 1.0  initial release
// ============================================================================
module ct_spsram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // Port that wins a tie; reset value favours port 0
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Only an actual grant moves the pointer, to the other port
  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ct_spsram_256x23_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ct_spsram_256x23_ctrl
// Purpose: Controller for an external 256x23 single-port SRAM. After reset it
//          zero-fills the whole array, then serves two requesters through a
//          round-robin arbiter, one access per cycle. flush_req in RUN
//          re-runs the zero fill.
// Ports  : clk, rst   - clock, asynchronous active-high reset
//          bus        - requester ports, read return, status, SRAM pins
// Rev    : 1.0  initial release
// ============================================================================
module ct_spsram_256x23_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  ct_spsram_256x23_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  init_done_q;
  logic                  rd_vld_q;
  logic                  rd_id_q;
  logic [DATA_WIDTH-1:0] rd_hold_q;

  logic [1:0]            w_gnt;
  logic                  w_sel;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [DATA_WIDTH-1:0] w_sel_wmask;
  logic                  w_rd_fire;

  // --------------------------------------------------------------------------
  // Arbitration: grants are only possible in RUN
  // --------------------------------------------------------------------------
  ct_spsram_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_RUN),
    .req_i ({bus.p1_req, bus.p0_req}),
    .gnt_o (w_gnt)
  );

  assign bus.p0_gnt = w_gnt[0];
  assign bus.p1_gnt = w_gnt[1];

  assign w_sel       = w_gnt[1];
  assign w_sel_wr    = w_sel ? bus.p1_wr    : bus.p0_wr;
  assign w_sel_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;
  assign w_sel_wmask = w_sel ? bus.p1_wmask : bus.p0_wmask;
  assign w_rd_fire   = (|w_gnt) & ~w_sel_wr;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. flush_req outside RUN is deliberately ignored so an
  // ongoing sweep is never restarted.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: state_d = ST_INIT;
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.flush_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: SRAM pin outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.ram_cen  = 1'b1;
    bus.ram_gwen = 1'b1;
    bus.ram_wen  = '1;
    bus.ram_d    = '0;
    bus.ram_a    = '0;
    case (state_q)
      ST_INIT: begin
        bus.ram_cen  = 1'b0;
        bus.ram_gwen = 1'b0;
        bus.ram_wen  = '0;
        bus.ram_a    = cnt_q;
      end
      ST_RUN: begin
        if (|w_gnt) begin
          bus.ram_cen = 1'b0;
          bus.ram_a   = w_sel_addr;
          if (w_sel_wr) begin
            // An all-zero mask still uses the slot but writes nothing
            bus.ram_gwen = ~|w_sel_wmask;
            bus.ram_wen  = ~w_sel_wmask;
            bus.ram_d    = w_sel_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read return: ram_q is valid the cycle after the access, so it is passed
  // straight through while rd_vld is high and captured for the hold value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_id_q   <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      rd_vld_q <= w_rd_fire;
      if (w_rd_fire) begin
        rd_id_q <= w_sel;
      end
      if (rd_vld_q) begin
        rd_hold_q <= bus.ram_q;
      end
    end
  end

  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_id     = rd_id_q;
  assign bus.rd_data   = rd_vld_q ? bus.ram_q : rd_hold_q;
  assign bus.init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_spsram_256x23_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ct_spsram_256x23_ctrl
// Purpose: Self-checking bench for ct_spsram_256x23_ctrl with an SRAM model,
//          a behavioural reference model and directed plus random stimulus.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ct_spsram_256x23_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_spsram_256x23_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(23)) bus ();

  ct_spsram_256x23_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM macro model: bit-masked write, registered read
  logic [22:0] sram [256];
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 23'($urandom);
    bus.ram_q = '0;
  end
  always @(posedge clk) begin
    if (!bus.ram_cen) begin
      if (!bus.ram_gwen)
        sram[bus.ram_a] <= (sram[bus.ram_a] & bus.ram_wen) | (bus.ram_d & ~bus.ram_wen);
      else
        bus.ram_q <= sram[bus.ram_a];
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: timeline of cycles since reset release, a flat memory
  // image, a tie-break pointer and a one-deep expected read return.
  // --------------------------------------------------------------------------
  int          m_cyc, m_run_at;
  logic        m_prio, m_pend, m_pend_id;
  logic [22:0] m_pend_data, m_hold;
  logic [22:0] m_mem [256];
  logic        e_run, e_init, e_sel, e_cen, e_gwen, e_wr_chk;
  logic [1:0]  e_gnt, e_req;
  logic [7:0]  e_a;
  logic [22:0] e_wen, e_d, e_mk;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt0", bus.p0_gnt, 0);
      chk("rst_gnt1", bus.p1_gnt, 0);
      chk("rst_cen", bus.ram_cen, 1);
      chk("rst_gwen", bus.ram_gwen, 1);
      chk("rst_wen", bus.ram_wen, 23'h7FFFFF);
      chk("rst_init_done", bus.init_done, 0);
      chk("rst_rd_vld", bus.rd_vld, 0);
      chk("rst_rd_id", bus.rd_id, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      m_cyc = 0; m_run_at = 257; m_prio = 0; m_pend = 0; m_pend_id = 0;
      m_pend_data = 0; m_hold = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
    end else begin
      e_run  = (m_cyc >= m_run_at);
      e_init = (m_cyc >= m_run_at - 256) && !e_run;
      e_req  = {bus.p1_req, bus.p0_req};
      e_gnt  = 2'b00;
      if (e_run) e_gnt = (e_req == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : e_req;
      chk("init_done", bus.init_done, e_run);
      chk("gnt0", bus.p0_gnt, e_gnt[0]);
      chk("gnt1", bus.p1_gnt, e_gnt[1]);

      e_sel = e_gnt[1];
      e_mk  = e_sel ? bus.p1_wmask : bus.p0_wmask;
      e_cen = 1; e_gwen = 1; e_wen = '1; e_d = 0; e_a = 0; e_wr_chk = 1;
      if (e_init) begin
        e_cen = 0; e_gwen = 0; e_wen = 0; e_d = 0;
        e_a = 8'(m_cyc - (m_run_at - 256));
      end else if (e_gnt != 2'b00) begin
        e_cen = 0;
        e_a   = e_sel ? bus.p1_addr : bus.p0_addr;
        if (e_sel ? bus.p1_wr : bus.p0_wr) begin
          e_gwen = (e_mk == 0);
          e_wen  = ~e_mk;
          e_d    = e_sel ? bus.p1_wdata : bus.p0_wdata;
        end else begin
          e_wr_chk = 0;
        end
      end
      chk("ram_cen", bus.ram_cen, e_cen);
      chk("ram_gwen", bus.ram_gwen, e_gwen);
      if (!e_cen) chk("ram_a", bus.ram_a, e_a);
      if (e_wr_chk) chk("ram_wen", bus.ram_wen, e_wen);
      if (!e_gwen) chk("ram_d", bus.ram_d & ~bus.ram_wen, e_d & ~e_wen);

      chk("rd_vld", bus.rd_vld, m_pend);
      if (m_pend) begin
        chk("rd_id", bus.rd_id, m_pend_id);
        m_hold = m_pend_data;
      end
      chk("rd_data", bus.rd_data, m_hold);

      // advance the model past this cycle, in grant order
      m_pend = 0;
      if (e_gnt != 2'b00) begin
        if (e_sel ? bus.p1_wr : bus.p0_wr) begin
          m_mem[e_a] = (m_mem[e_a] & ~e_mk) | (e_d & e_mk);
        end else begin
          m_pend = 1; m_pend_id = e_sel; m_pend_data = m_mem[e_a];
        end
        m_prio = ~e_sel;
      end
      if (e_run && bus.flush_req) begin
        m_run_at = m_cyc + 257;
        for (int i = 0; i < 256; i++) m_mem[i] = 0;
      end
      m_cyc++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_p0(input logic r, input logic w, input logic [7:0] a,
                        input logic [22:0] d, input logic [22:0] m);
    bus.p0_req = r; bus.p0_wr = w; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_wmask = m;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic [7:0] a,
                        input logic [22:0] d, input logic [22:0] m);
    bus.p1_req = r; bus.p1_wr = w; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_wmask = m;
  endtask

  function automatic logic [22:0] rnd_mask();
    case ($urandom % 4)
      0:       return 23'h0;
      1:       return 23'h7FFFFF;
      default: return 23'($urandom);
    endcase
  endfunction

  task automatic wait_run();
    int n = 0;
    while (!bus.init_done && n < 600) begin
      @(negedge clk); n++;
    end
    chk("run_reached", bus.init_done, 1);
  endtask

  logic       g0, g1;
  logic [3:0] alt_pat;
  int         k;

  initial begin
    bus.flush_req = 0;
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    g0 = 0; g1 = 0;

    // Reset, then time the sweep: init_done must first be seen in cycle 258
    repeat (3) @(posedge clk);
    #1 rst = 0;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!bus.init_done && k < 400);
    chk("init_done_rise_cycle", k, 258);

    // Write then read-after-write from the other port
    tick(); set_p0(1, 1, 8'h12, 23'h5A5A5, 23'h7FFFFF);
    @(negedge clk); chk("raw_wr_gnt", bus.p0_gnt, 1);
    tick(); set_p0(0, 0, 0, 0, 0); set_p1(1, 0, 8'h12, 0, 0);
    @(negedge clk); chk("raw_rd_gnt", bus.p1_gnt, 1);
    tick(); set_p1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_rd_vld", bus.rd_vld, 1);
    chk("raw_rd_id", bus.rd_id, 1);
    chk("raw_rd_data", bus.rd_data, 23'h5A5A5);

    // Both held for four cycles: p0, p1, p0, p1
    alt_pat = 4'b0101;
    tick(); set_p0(1, 0, 8'h01, 0, 0); set_p1(1, 0, 8'h02, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_gnt0", bus.p0_gnt, alt_pat[i]);
      chk("alt_gnt1", bus.p1_gnt, !alt_pat[i]);
      if (i < 3) tick();
    end

    // Full write then byte-masked write of zero, then read back
    tick(); set_p1(0, 0, 0, 0, 0); set_p0(1, 1, 8'h80, 23'h7FFFFF, 23'h7FFFFF);
    @(negedge clk);
    tick(); set_p0(1, 1, 8'h80, 23'h000000, 23'h0000FF);
    @(negedge clk);
    tick(); set_p0(1, 0, 8'h80, 0, 0);
    @(negedge clk);
    tick(); set_p0(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mask_rd_vld", bus.rd_vld, 1);
    chk("mask_rd_data", bus.rd_data, 23'h7FFF00);

    // Random traffic with occasional flushes, requests held until granted
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!bus.p0_req || g0)
        set_p0(($urandom % 3) != 0, $urandom % 2, 8'($urandom_range(0, 15)),
               23'($urandom), rnd_mask());
      if (!bus.p1_req || g1)
        set_p1(($urandom % 3) != 0, $urandom % 2, 8'($urandom_range(0, 15)),
               23'($urandom), rnd_mask());
      bus.flush_req = (($urandom % 400) == 0);
      @(negedge clk);
      g0 = bus.p0_gnt; g1 = bus.p1_gnt;
    end
    tick();
    bus.flush_req = 0; set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    @(negedge clk);
    wait_run();

    // Flush with a read granted in the flush cycle, then a held read
    tick(); set_p0(1, 1, 8'h05, 23'h000123, 23'h7FFFFF);
    @(negedge clk); chk("fl_wr_gnt", bus.p0_gnt, 1);
    tick(); set_p0(0, 0, 0, 0, 0); bus.flush_req = 1; set_p1(1, 0, 8'h05, 0, 0);
    @(negedge clk); chk("fl_cycle_gnt", bus.p1_gnt, 1);
    tick(); bus.flush_req = 0;
    @(negedge clk);
    chk("fl_rd_vld", bus.rd_vld, 1);
    chk("fl_rd_data", bus.rd_data, 23'h000123);
    chk("fl_init_done_fall", bus.init_done, 0);
    k = 1;
    while (!bus.p1_gnt && k < 400) begin
      @(negedge clk); k++;
    end
    chk("fl_regrant_cycle", k, 257);
    tick(); set_p1(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fl_zero_vld", bus.rd_vld, 1);
    chk("fl_zero_data", bus.rd_data, 0);

    // Reset pulse in the middle of the sweep
    tick(); rst = 1;
    tick(); tick(); rst = 0;
    repeat (102) @(negedge clk);
    chk("sweep_cnt100", bus.ram_a, 100);
    #1 rst = 1;
    #1;
    chk("async_rst_cen", bus.ram_cen, 1);
    chk("async_rst_gwen", bus.ram_gwen, 1);
    chk("async_rst_init_done", bus.init_done, 0);
    tick(); tick(); rst = 0;
    @(negedge clk); chk("restart_wait_cen", bus.ram_cen, 1);
    @(negedge clk);
    chk("restart_cen", bus.ram_cen, 0);
    chk("restart_addr", bus.ram_a, 0);
    wait_run();
    tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ct_spsram_256x23_ctrl.md
CT_SPSRAM_256X23_CTRL -- requirements
Module: ct_spsram_256x23_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SRAM address width (DEPTH = 2**ADDR_WIDTH = 256).
REQ-002 Parameter DATA_WIDTH, default 23, SRAM word width.
REQ-003 One clock and one reset: reset is asynchronous and active-high.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 flush_req  input  1  single-cycle pulse; re-initialise the whole array to zero.
REQ-007 init_done  output  1  high when the array is initialised and requests are accepted.
REQ-008 pN_req (N=0,1)  input  1  request valid; held until granted.
REQ-009 pN_wr  input  1  1 = write, 0 = read.
REQ-010 pN_addr  input  ADDR_WIDTH  word address.
REQ-011 pN_wdata  input  DATA_WIDTH  write data.
REQ-012 pN_wmask  input  DATA_WIDTH  active-high per-bit write enable.
REQ-013 pN_gnt  output  1  request accepted this cycle (combinational).
REQ-014 rd_vld  output  1  read data valid.
REQ-015 rd_id  output  1  requester index that owns rd_data.
REQ-016 rd_data  output  DATA_WIDTH  read data.
REQ-017 ram_a  output  ADDR_WIDTH  SRAM address.
REQ-018 ram_cen  output  1  SRAM chip enable, active-low.
REQ-019 ram_gwen  output  1  SRAM global write enable, active-low.
REQ-020 ram_wen  output  DATA_WIDTH  SRAM bit write enable, active-low.
REQ-021 ram_d  output  DATA_WIDTH  SRAM write data.
REQ-022 ram_q  input  DATA_WIDTH  SRAM read data, valid one cycle after a read access.

Function
REQ-023 FSM states: WAIT (post-reset idle), INIT (zero sweep), RUN; WAIT -> INIT unconditionally after one cycle.
REQ-024 INIT: 8-bit counter starts at 0; each cycle drives ram_cen=0, ram_gwen=0, ram_wen=all 0, ram_d=0, ram_a=counter; counter increments by 1.
REQ-025 INIT -> RUN after the write at counter=DEPTH-1, i.e. exactly 256 INIT cycles; the counter wraps to 0.
REQ-026 init_done is registered: 1 only in RUN; 0 in WAIT and INIT.
REQ-027 No pN_gnt is asserted outside RUN; requests stay pending.
REQ-028 RUN: at most one SRAM access per cycle; ram_cen=1, ram_gwen=1, ram_wen=all 1 when no grant is issued.
REQ-029 Single requester: granted in the same cycle it asserts req.
REQ-030 Both requesting: round-robin; grant the port not granted most recently; the pointer updates only on a grant; after reset the pointer favours p0.
REQ-031 Granted write: ram_gwen=0, ram_wen=~pN_wmask, ram_d=pN_wdata, ram_a=pN_addr; a write with all-zero mask still consumes the slot, with ram_gwen=1.
REQ-032 Granted read at cycle T: ram_gwen=1; at T+1, rd_vld=1, rd_id=N, rd_data=ram_q; otherwise rd_vld=0 and rd_data holds its last value.
REQ-033 Back-to-back reads are allowed every cycle; throughput is 1 access/cycle.
REQ-034 Read and write ordering is by grant order; a read granted the cycle after a write to the same address returns the new data.
REQ-035 flush_req in RUN: the current cycle's grant, if any, completes; next state is INIT with counter 0; init_done falls the next cycle.
REQ-036 flush_req in WAIT or INIT is ignored; the sweep is not restarted.
REQ-037 A read granted in the flush cycle still returns rd_vld at T+1.

Reset
REQ-038 While RST=1: state=WAIT, counter=0, RR pointer=p0, init_done=0, rd_vld=0, rd_id=0, rd_data=0, pN_gnt=0, ram_cen=1, ram_gwen=1, ram_wen=all 1.
REQ-039 RST asserted mid-INIT or mid-RUN aborts immediately; after release the full 256-entry sweep repeats.

Structure
REQ-040 Shared package ct_spsram_ctrl_pkg holds ADDR_WIDTH, DATA_WIDTH, DEPTH defaults and the FSM state enum (WAIT, INIT, RUN).
REQ-041 One sub-module, ct_spsram_rr_arb2: a 2-way round-robin arbiter with req[1:0] in, gnt[1:0] out, an enable input, and an internal last-grant pointer.
REQ-042 The SRAM macro is instantiated outside this block.

Verification
REQ-043 Release reset -> 1 idle cycle, then exactly 256 consecutive writes of 0 to addresses 0..255; init_done rises in cycle 258.
REQ-044 p0 write addr 0x12 data 0x5A5A5, mask all ones; next cycle p1 read 0x12 -> p1_gnt same cycle; 1 cycle later rd_vld=1, rd_id=1, rd_data=0x5A5A5.
REQ-045 p0 and p1 hold req for 4 cycles -> grants alternate p0, p1, p0, p1.
REQ-046 p0 write 0x7FFFFF then masked write 0x000000 with mask 0x0000FF to addr 0x80; read 0x80 -> rd_data=0x7FFF00.
REQ-047 flush_req while p1 holds a read request -> flush-cycle grant completes, then 256 INIT cycles with no gnt; p1 is granted in the first RUN cycle; previously written addresses read 0.
REQ-048 RST pulse at INIT counter=100 -> all outputs return to reset values; after release the sweep restarts at address 0.
